// File: rtl/vector_registers.sv
// Vector register file: NREGS x LANES x LANE_W, two combinational reads, one masked write,
// post-reset sequential clear. Optional same-cycle write bypass under `VREG_BYPASS_EN`.
module vector_registers #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    WriteEn,
  input  logic [LANES-1:0]        LaneMask,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [$clog2(NREGS)-1:0] Rs1,
  input  logic [$clog2(NREGS)-1:0] Rs2,
  input  logic [LANES*LANE_W-1:0] InputData,
  output logic [LANES*LANE_W-1:0] Rout1,
  output logic [LANES*LANE_W-1:0] Rout2,
  output logic                    Busy
);

  localparam int ADDR_W = $clog2(NREGS);
  localparam int DW     = LANES * LANE_W;

  typedef enum logic [0:0] {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                busy;
  logic [DW-1:0]       regs [NREGS];
  logic [DW-1:0]       rout1;
  logic [DW-1:0]       rout2;

  // Control: clear sequencer; cnt wraps to 0 exactly as the last register is cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == ADDR_W'(NREGS - 1)) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  // Array: clear engine owns the array during CLEAR, write port only in READY
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[cnt] <= '0;
      end else if (WriteEn && rd != '0) begin
        for (int i = 0; i < LANES; i++) begin
          if (LaneMask[i]) regs[rd][i*LANE_W +: LANE_W] <= InputData[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_comb begin
    rout1 = '0;
    rout2 = '0;
    if (state == READY) begin
      if (Rs1 != '0) rout1 = regs[Rs1];
      if (Rs2 != '0) rout2 = regs[Rs2];
`ifdef VREG_BYPASS_EN
      // rd != 0 guarantees a bypass never leaks data onto a register-0 read
      for (int i = 0; i < LANES; i++) begin
        if (WriteEn && LaneMask[i] && rd != '0) begin
          if (Rs1 == rd) rout1[i*LANE_W +: LANE_W] = InputData[i*LANE_W +: LANE_W];
          if (Rs2 == rd) rout2[i*LANE_W +: LANE_W] = InputData[i*LANE_W +: LANE_W];
        end
      end
`endif
    end
  end

  assign Rout1 = rout1;
  assign Rout2 = rout2;
  assign Busy  = busy;

endmodule

// File: tb/tb_vector_registers.sv
// Directed bench for vector_registers (LANES=4, LANE_W=32, NREGS=16).
module tb_vector_registers;

  logic         clk = 1'b0;
  logic         rst;
  logic         WriteEn;
  logic [3:0]   LaneMask;
  logic [3:0]   rd;
  logic [3:0]   Rs1;
  logic [3:0]   Rs2;
  logic [127:0] InputData;
  logic [127:0] Rout1;
  logic [127:0] Rout2;
  logic         Busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vector_registers #(.LANES(4), .LANE_W(32), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .WriteEn(WriteEn), .LaneMask(LaneMask), .rd(rd),
    .Rs1(Rs1), .Rs2(Rs2), .InputData(InputData),
    .Rout1(Rout1), .Rout2(Rout2), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [127:0] d);
    WriteEn = 1'b1; rd = a; LaneMask = m; InputData = d;
    step();
    WriteEn = 1'b0;
  endtask

  localparam logic [127:0] V_DCBA = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] V_44   = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] V_MIX  = {32'hDDDD_DDDD, 32'h33, 32'hBBBB_BBBB, 32'h11};
  localparam logic [127:0] V_R1   = {32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001};
  localparam logic [127:0] V_R15  = {32'hF00D_0004, 32'hF00D_0003, 32'hF00D_0002, 32'hF00D_0001};
  localparam logic [127:0] V_OLD  = {32'd8, 32'd7, 32'd6, 32'd5};
  localparam logic [127:0] V_NEW  = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] V_MRG  = {32'd8, 32'd7, 32'd2, 32'd1};

  int n;

  initial begin
    rst = 1'b1; WriteEn = 1'b0; LaneMask = '0; rd = '0; Rs1 = '0; Rs2 = '0; InputData = '0;
    step();
    rst = 1'b0;
    chk("busy_after_rst", Busy, 1'b1);

    // First clear: reads forced to zero, writes in cycles 3 and 12 ignored
    Rs1 = 4'd5; Rs2 = 4'd15;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      WriteEn = (n == 2 || n == 11); rd = (n == 2) ? 4'd7 : 4'd2;
      LaneMask = 4'hF; InputData = '1;
      #1;
      chk("clear_rout1", Rout1, '0);
      chk("clear_rout2", Rout2, '0);
      step();
      n++;
    end
    WriteEn = 1'b0;
    chk("clear_len", 128'(n), 128'd16);

    Rs1 = 4'd5; Rs2 = 4'd7; #1;
    chk("post_clear_r5", Rout1, '0);
    chk("clear_write_r7", Rout2, '0);
    Rs1 = 4'd2; #1;
    chk("clear_write_r2", Rout1, '0);

    // Masked write
    wr(4'd3, 4'hF, V_DCBA);
    Rs1 = 4'd3; #1;
    chk("full_write", Rout1, V_DCBA);
    wr(4'd3, 4'b0101, V_44);
    Rs1 = 4'd3; Rs2 = 4'd3; #1;
    chk("masked_rout1", Rout1, V_MIX);
    chk("masked_rout2", Rout2, V_MIX);

    // Register 0 hardwired
    wr(4'd1, 4'hF, V_R1);
    wr(4'd15, 4'hF, V_R15);
    wr(4'd0, 4'hF, '1);
    Rs1 = 4'd0; Rs2 = 4'd0; #1;
    chk("r0_rout1", Rout1, '0);
    chk("r0_rout2", Rout2, '0);
    Rs1 = 4'd1; Rs2 = 4'd15; #1;
    chk("r1_kept", Rout1, V_R1);
    chk("r15_kept", Rout2, V_R15);
    Rs1 = 4'd3; #1;
    chk("r3_kept", Rout1, V_MIX);

    // Same-cycle read/write
    wr(4'd9, 4'hF, V_OLD);
    WriteEn = 1'b1; rd = 4'd9; LaneMask = 4'b0011; InputData = V_NEW;
    Rs1 = 4'd9; Rs2 = 4'd9; #1;
`ifdef VREG_BYPASS_EN
    chk("same_cycle_rout1", Rout1, V_MRG);
    chk("same_cycle_rout2", Rout2, V_MRG);
`else
    chk("same_cycle_rout1", Rout1, V_OLD);
    chk("same_cycle_rout2", Rout2, V_OLD);
`endif
    step();
    WriteEn = 1'b0; #1;
    chk("next_cycle_rout1", Rout1, V_MRG);

    wr(4'd9, 4'h0, '1);
    Rs1 = 4'd9; #1;
    chk("zero_mask", Rout1, V_MRG);

    // Reset again, then re-assert in CLEAR cycle 10
    rst = 1'b1;
    step();
    rst = 1'b0;
    Rs1 = 4'd3; Rs2 = 4'd9; #1;
    chk("rst2_busy", Busy, 1'b1);
    chk("rst2_rout1", Rout1, '0);
    chk("rst2_rout2", Rout2, '0);
    for (int i = 0; i < 9; i++) step();
    chk("busy_cycle10", Busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("midclear_len", 128'(n), 128'd16);
    Rs1 = 4'd3; Rs2 = 4'd9; #1;
    chk("reclear_r3", Rout1, '0);
    chk("reclear_r9", Rout2, '0);
    Rs1 = 4'd15; Rs2 = 4'd1; #1;
    chk("reclear_r15", Rout1, '0);
    chk("reclear_r1", Rout2, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
